// File: rtl/key_sw_conditioner.sv
// Purpose : 2-flop sync + debounce of raw push-buttons/slide switches, plus press/release/long-press/switch-change pulses.
// Latency : debounced level and its event pulse change 1+DEBOUNCE_CYCLES edges after the pin settles; key_long fires LONG_PRESS_CYCLES cycles after key_press.
// Backpr. : none; free-running level conditioner, every output is a registered level or a single-cycle pulse.
//
// Ports:
//   clk_clk, reset_reset    : 50 MHz system clock, asynchronous active-high reset
//   key_raw_n / sw_raw      : raw board pins (keys active-low, switches active-high)
//   key_db_n / sw_db        : debounced levels, feed the Qsys PIO exports
//   key_press/key_release   : 1-cycle pulses on debounced key 1->0 / 0->1
//   key_long                : 1-cycle pulse once per press held for LONG_PRESS_CYCLES
//   sw_change               : 1-cycle pulse when any debounced switch bit changes
//   sw_valid                : sticky flag, set once every switch finished its first debounce window
module key_sw_conditioner #(
  parameter int N_KEY             = 2,
  parameter int N_SW              = 4,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 100000000
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [N_KEY-1:0] key_raw_n,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_KEY-1:0] key_db_n,
  output logic [N_SW-1:0]  sw_db,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release,
  output logic [N_KEY-1:0] key_long,
  output logic             sw_change,
  output logic             sw_valid
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  // One extra code point so the long-press counter can park past the firing value.
  localparam int LP_W    = $clog2(LONG_PRESS_CYCLES + 1);
  // First window spans the synchroniser fill (2 edges) plus one debounce window,
  // so sw_valid rises on the same edge the first possible sw_db update lands.
  localparam int WIN_END = DEBOUNCE_CYCLES + 2;
  localparam int WIN_W   = $clog2(WIN_END + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
  localparam logic [LP_W-1:0]  LP_FIRE  = LP_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [LP_W-1:0]  LP_SAT   = LP_W'(LONG_PRESS_CYCLES);
  localparam logic [LP_W-1:0]  LP_ONE   = LP_W'(1);
  localparam logic [WIN_W-1:0] WIN_DONE = WIN_W'(WIN_END);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

  logic [N_KEY-1:0] key_s1, key_s2, key_db_nxt, key_long_nxt;
  logic [N_SW-1:0]  sw_s1, sw_s2, sw_db_nxt, win_done_nxt;

  logic [DB_W-1:0]  key_cnt     [N_KEY];
  logic [DB_W-1:0]  key_cnt_nxt [N_KEY];
  logic [DB_W-1:0]  sw_cnt      [N_SW];
  logic [DB_W-1:0]  sw_cnt_nxt  [N_SW];
  logic [LP_W-1:0]  lp_cnt      [N_KEY];
  logic [LP_W-1:0]  lp_cnt_nxt  [N_KEY];
  logic [WIN_W-1:0] win_cnt     [N_SW];
  logic [WIN_W-1:0] win_cnt_nxt [N_SW];

  // Key debounce: count consecutive samples that disagree with the accepted
  // level; any agreeing sample (a bounce back) restarts the count.
  always_comb begin
    key_db_nxt = key_db_n;
    for (int i = 0; i < N_KEY; i++) begin
      key_cnt_nxt[i] = '0;
      if (key_s2[i] != key_db_n[i]) begin
        if (key_cnt[i] == DB_LAST) begin
          key_db_nxt[i] = key_s2[i];
        end else begin
          key_cnt_nxt[i] = key_cnt[i] + DB_ONE;
        end
      end
    end
  end

  // Switch debounce, same rule as the keys.
  always_comb begin
    sw_db_nxt = sw_db;
    for (int i = 0; i < N_SW; i++) begin
      sw_cnt_nxt[i] = '0;
      if (sw_s2[i] != sw_db[i]) begin
        if (sw_cnt[i] == DB_LAST) begin
          sw_db_nxt[i] = sw_s2[i];
        end else begin
          sw_cnt_nxt[i] = sw_cnt[i] + DB_ONE;
        end
      end
    end
  end

  // Long press: lp_cnt holds the number of cycles since key_press while the key
  // stays down. It fires while passing LP_FIRE and then parks at LP_SAT, which
  // is what stops a repeat until the key is released.
  always_comb begin
    for (int i = 0; i < N_KEY; i++) begin
      key_long_nxt[i] = 1'b0;
      if (key_db_n[i]) begin
        lp_cnt_nxt[i] = '0;
      end else if (lp_cnt[i] != LP_SAT) begin
        lp_cnt_nxt[i]   = lp_cnt[i] + LP_ONE;
        key_long_nxt[i] = (lp_cnt[i] == LP_FIRE);
      end else begin
        lp_cnt_nxt[i] = lp_cnt[i];
      end
    end
  end

  // First-window counters, saturating at WIN_DONE.
  always_comb begin
    for (int i = 0; i < N_SW; i++) begin
      if (win_cnt[i] == WIN_DONE) begin
        win_cnt_nxt[i] = win_cnt[i];
      end else begin
        win_cnt_nxt[i] = win_cnt[i] + WIN_ONE;
      end
      win_done_nxt[i] = (win_cnt_nxt[i] == WIN_DONE);
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      key_s1      <= '1;
      key_s2      <= '1;
      key_db_n    <= '1;
      sw_s1       <= '0;
      sw_s2       <= '0;
      sw_db       <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_long    <= '0;
      sw_change   <= 1'b0;
      sw_valid    <= 1'b0;
      for (int i = 0; i < N_KEY; i++) begin
        key_cnt[i] <= '0;
        lp_cnt[i]  <= '0;
      end
      for (int i = 0; i < N_SW; i++) begin
        sw_cnt[i]  <= '0;
        win_cnt[i] <= '0;
      end
    end else begin
      key_s1      <= key_raw_n;
      key_s2      <= key_s1;
      sw_s1       <= sw_raw;
      sw_s2       <= sw_s1;
      key_db_n    <= key_db_nxt;
      sw_db       <= sw_db_nxt;
      // Pulses come from the same next-state terms as the levels, so each
      // pulse is high in exactly the cycle its level changes.
      key_press   <= key_db_n & ~key_db_nxt;
      key_release <= ~key_db_n & key_db_nxt;
      key_long    <= key_long_nxt;
      sw_change   <= |(sw_db ^ sw_db_nxt);
      sw_valid    <= sw_valid | (&win_done_nxt);
      for (int i = 0; i < N_KEY; i++) begin
        key_cnt[i] <= key_cnt_nxt[i];
        lp_cnt[i]  <= lp_cnt_nxt[i];
      end
      for (int i = 0; i < N_SW; i++) begin
        sw_cnt[i]  <= sw_cnt_nxt[i];
        win_cnt[i] <= win_cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_key_sw_conditioner.sv
module tb_key_sw_conditioner;

  localparam int N_KEY = 2;
  localparam int N_SW  = 4;
  localparam int DB    = 4;
  localparam int LP    = 20;
  localparam logic [63:0] DMASK = (64'd1 << DB) - 64'd1;

  logic             clk_clk = 1'b0;
  logic             reset_reset = 1'b0;
  logic [N_KEY-1:0] key_raw_n = '1;
  logic [N_SW-1:0]  sw_raw = '0;
  logic [N_KEY-1:0] key_db_n, key_press, key_release, key_long;
  logic [N_SW-1:0]  sw_db;
  logic             sw_change, sw_valid;

  key_sw_conditioner #(
    .N_KEY(N_KEY), .N_SW(N_SW), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .key_raw_n(key_raw_n), .sw_raw(sw_raw),
    .key_db_n(key_db_n), .sw_db(sw_db),
    .key_press(key_press), .key_release(key_release), .key_long(key_long),
    .sw_change(sw_change), .sw_valid(sw_valid)
  );

  always #5 clk_clk = ~clk_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: per-channel history of pin samples (bit 0 = newest edge).
  // A level is accepted when the DB samples that have fully crossed the
  // synchroniser all disagree with the current debounced level.
  logic [63:0]      key_hist [N_KEY];
  logic [63:0]      sw_hist  [N_SW];
  logic [N_KEY-1:0] m_key_db, m_press, m_release, m_long;
  logic [N_SW-1:0]  m_sw_db;
  logic             m_swchg, m_valid;
  int               press_edge [N_KEY];
  int               ecount = 0;
  int               since  = 0;

  // Observation log, compared later against constants derived from DB/LP.
  int last_press [N_KEY], last_release [N_KEY], last_long [N_KEY];
  int press_cnt [N_KEY], long_cnt [N_KEY];
  int last_swchg = 0, swchg_cnt = 0, valid_rise = -1;
  bit valid_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_KEY; i++) begin
      key_hist[i]   = '1;
      press_edge[i] = -100000;
    end
    for (int i = 0; i < N_SW; i++) sw_hist[i] = '0;
    m_key_db   = '1;
    m_sw_db    = '0;
    m_press    = '0;
    m_release  = '0;
    m_long     = '0;
    m_swchg    = 1'b0;
    m_valid    = 1'b0;
    since      = 0;
    valid_seen = 1'b0;
    valid_rise = -1;
  endtask

  task automatic model_step();
    logic [63:0] w;
    logic        prev;
    if (reset_reset) begin
      model_reset();
      return;
    end
    ecount++;
    since++;
    m_press = '0; m_release = '0; m_long = '0; m_swchg = 1'b0;
    for (int i = 0; i < N_KEY; i++) begin
      key_hist[i] = {key_hist[i][62:0], key_raw_n[i]};
      w    = (key_hist[i] >> 2) & DMASK;
      prev = m_key_db[i];
      if (prev == 1'b0 && (ecount - press_edge[i]) == LP) m_long[i] = 1'b1;
      if (w == (prev ? 64'd0 : DMASK)) begin
        m_key_db[i] = ~prev;
        if (prev) begin
          m_press[i]    = 1'b1;
          press_edge[i] = ecount;
        end else begin
          m_release[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < N_SW; i++) begin
      sw_hist[i] = {sw_hist[i][62:0], sw_raw[i]};
      w    = (sw_hist[i] >> 2) & DMASK;
      prev = m_sw_db[i];
      if (w == (prev ? 64'd0 : DMASK)) begin
        m_sw_db[i] = ~prev;
        m_swchg    = 1'b1;
      end
    end
    m_valid = (since >= DB + 2);
  endtask

  task automatic check_all();
    chk("key_db_n",    32'(key_db_n),    32'(m_key_db));
    chk("sw_db",       32'(sw_db),       32'(m_sw_db));
    chk("key_press",   32'(key_press),   32'(m_press));
    chk("key_release", 32'(key_release), 32'(m_release));
    chk("key_long",    32'(key_long),    32'(m_long));
    chk("sw_change",   32'(sw_change),   32'(m_swchg));
    chk("sw_valid",    32'(sw_valid),    32'(m_valid));
  endtask

  task automatic record();
    for (int i = 0; i < N_KEY; i++) begin
      if (key_press[i] === 1'b1)   begin last_press[i] = ecount; press_cnt[i]++; end
      if (key_release[i] === 1'b1) last_release[i] = ecount;
      if (key_long[i] === 1'b1)    begin last_long[i] = ecount; long_cnt[i]++; end
    end
    if (sw_change === 1'b1) begin last_swchg = ecount; swchg_cnt++; end
    if (sw_valid === 1'b1 && !valid_seen) begin
      valid_seen = 1'b1;
      valid_rise = since;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
      model_step();
      check_all();
      record();
    end
  endtask

  initial begin
    int t, p0, l1, c;
    for (int i = 0; i < N_KEY; i++) begin
      last_press[i] = 0; last_release[i] = 0; last_long[i] = 0;
      press_cnt[i] = 0; long_cnt[i] = 0;
    end
    model_reset();

    // Reset state, then idle pins: sw_valid rises after sync fill + one window.
    #2 reset_reset = 1'b1;
    #1 check_all();
    tick(3);
    reset_reset = 1'b0;
    tick(10);
    chk("valid_rise", 32'(valid_rise), 32'(DB + 2));

    // Single key press: 1+DB edges of latency, other key untouched.
    p0 = press_cnt[0];
    t  = ecount + 1;
    key_raw_n[0] = 1'b0;
    tick(10);
    chk("press0_lat", 32'(last_press[0] - t), 32'(DB + 1));
    chk("press0_cnt", 32'(press_cnt[0] - p0), 32'd1);
    chk("key1_quiet", 32'(press_cnt[1]), 32'd0);
    t = ecount + 1;
    key_raw_n[0] = 1'b1;
    tick(10);
    chk("rel0_lat", 32'(last_release[0] - t), 32'(DB + 1));

    // Bouncing pin (2-cycle runs) must never be accepted.
    p0 = press_cnt[0];
    for (int k = 0; k < 20; k++) begin
      key_raw_n[0] = ((k / 2) % 2 == 1);
      tick(1);
    end
    key_raw_n[0] = 1'b1;
    tick(8);
    chk("glitch_press", 32'(press_cnt[0] - p0), 32'd0);

    // Long press on key 1, then release, then a short hold.
    l1 = long_cnt[1];
    t  = ecount + 1;
    key_raw_n[1] = 1'b0;
    tick(40);
    chk("press1_lat", 32'(last_press[1] - t), 32'(DB + 1));
    chk("long1_dist", 32'(last_long[1] - last_press[1]), 32'(LP));
    chk("long1_once", 32'(long_cnt[1] - l1), 32'd1);
    t = ecount + 1;
    key_raw_n[1] = 1'b1;
    tick(10);
    chk("rel1_lat", 32'(last_release[1] - t), 32'(DB + 1));
    l1 = long_cnt[1];
    key_raw_n[1] = 1'b0;
    tick(15);
    key_raw_n[1] = 1'b1;
    tick(12);
    chk("short_nolong", 32'(long_cnt[1] - l1), 32'd0);

    // Two switches on the same edge: one sw_change pulse.
    c = swchg_cnt;
    t = ecount + 1;
    sw_raw = 4'b1010;
    tick(8);
    chk("sw_db_1010", 32'(sw_db), 32'h0000_000a);
    chk("sw_lat", 32'(last_swchg - t), 32'(DB + 1));
    chk("sw_once", 32'(swchg_cnt - c), 32'd1);

    // Random segments: glitches, accepted levels and long holds on all channels.
    for (int s = 0; s < 40; s++) begin
      key_raw_n = 2'($urandom);
      sw_raw    = 4'($urandom);
      tick($urandom_range(1, 30));
    end
    key_raw_n = '1;
    sw_raw    = 4'b1010;
    tick(40);

    // Reset while key 0 is mid-debounce (counter at 2), pin kept low.
    key_raw_n[0] = 1'b0;
    tick(4);
    reset_reset = 1'b1;
    #1;
    model_reset();
    check_all();
    tick(2);
    reset_reset = 1'b0;
    p0 = press_cnt[0];
    t  = ecount + 1;
    tick(12);
    chk("rst_press_lat", 32'(last_press[0] - t), 32'(DB + 1));
    chk("rst_press_cnt", 32'(press_cnt[0] - p0), 32'd1);
    chk("rst_valid_rise", 32'(valid_rise), 32'(DB + 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
